cpu_cmd_queue_interface: RTL



---
 rtl/cpu_cmdq_pkg.sv | 56 +++++
 rtl/cpu_cmd_queue_interface_fifo.sv | 71 +++++++
 rtl/cpu_cmd_queue_interface.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_cmdq_pkg.sv
// Shared definitions for the CPU command-queue host interface: register map
// offsets (derived from the address width), status bit positions, executor
// opcodes and the execute-trigger address lookup.
package cpu_cmdq_pkg;

    // Executor opcodes understood by the graphics array
    localparam logic [7:0] OP_TEXTWRITE = 8'h00;
    localparam logic [7:0] OP_FILL      = 8'h01;
    localparam logic [7:0] OP_BLIT      = 8'h02;

    // Fixed low end of the register map
    localparam int MODE_ADDR           = 0;
    localparam int OPCODE_ADDR         = 1;
    localparam int ARG_BASE_ADDR       = 2;
    localparam int TEXTWRITE_EXEC_ADDR = 3;

    // Status byte layout
    localparam int ST_READY    = 7;
    localparam int ST_COUNT_HI = 6;
    localparam int ST_COUNT_LO = 4;
    localparam int ST_DONE     = 3;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_ERROR    = 1;
    localparam int ST_BUSY     = 0;

    // The top three bytes of the map hold the results and the status byte
    function automatic int result0Addr(input int addrW);
        return (1 << addrW) - 3;
    endfunction

    function automatic int result1Addr(input int addrW);
        return (1 << addrW) - 2;
    endfunction

    function automatic int statusAddr(input int addrW);
        return (1 << addrW) - 1;
    endfunction

    // One queued command is the opcode byte on top of every argument byte
    function automatic int cmdWidth(input int numArgs);
        return 8 * (numArgs + 1);
    endfunction

    // Text writes fire as soon as the character byte lands; every other
    // opcode waits for the last argument register to be written
    function automatic int exec_addr(input logic [7:0] opcode, input int numArgs);
        int result;
        if (opcode == OP_TEXTWRITE) begin
            result = TEXTWRITE_EXEC_ADDR;
        end else begin
            result = numArgs + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_cmd_queue_interface_fifo.sv
// Synchronous command FIFO with full/empty/count flags. A push and a pop in
// the same edge are both honoured, so a full FIFO can accept a new entry
// while one leaves. Reset is synchronous and active-low.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               pushData_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               popData_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign popData_o = mem_q[rdPtr_q];

    // Decide which transfers actually happen and where the pointers go next
    always_comb begin
        doPush  = push_i && (!full_o || pop_i);
        doPop   = pop_i && !empty_o;
        wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = doPop ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array needs no reset; the pointers decide what is valid
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/cpu_cmd_queue_interface.sv
// 6502-style host bus front end for the graphics array. The CPU fills the
// mode/opcode/argument registers; writing the execute-trigger address queues
// a snapshot of the command so several can be posted without polling. Queued
// commands are handed to the executor one at a time with a start pulse.
// Optional build macro CPU_CMDQ_IRQ_EN adds the irq_n output and the
// done flag in status bit 3.
module cpu_cmd_queue_interface
    import cpu_cmdq_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int NUM_ARGS   = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    phi2,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    input  logic                    rw,
    input  logic                    ce0,
    input  logic                    ce1b,
    output logic [7:0]              instruction,
    output logic [8*NUM_ARGS-1:0]   arg_data,
    output logic                    instruction_start,
    input  logic                    instruction_busy,
    input  logic                    instruction_finished,
    input  logic                    instruction_error,
    input  logic [7:0]              result_0,
    input  logic [7:0]              result_1,
`ifdef CPU_CMDQ_IRQ_EN
    output logic                    irq_n,
`endif
    output logic [7:0]              mode_control
);
    localparam int CMD_W  = cmdWidth(NUM_ARGS);
    localparam int ARGS_W = 8 * NUM_ARGS;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] MODE_A    = ADDR_W'(MODE_ADDR);
    localparam logic [ADDR_W-1:0] OPCODE_A  = ADDR_W'(OPCODE_ADDR);
    localparam logic [ADDR_W-1:0] RESULT0_A = ADDR_W'(result0Addr(ADDR_W));
    localparam logic [ADDR_W-1:0] RESULT1_A = ADDR_W'(result1Addr(ADDR_W));
    localparam logic [ADDR_W-1:0] STATUS_A  = ADDR_W'(statusAddr(ADDR_W));

    logic              sel, wrEn, rdEn, statusRead, trigger;
    logic              issue, completion;
    logic [ADDR_W-1:0] execA;
    logic [7:0]        readData, statusByte;
    logic              doneBit;

    logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    logic [CMD_W-1:0]  fifoPushData, fifoPopData;

    logic [7:0]        modeReg_q, modeReg_d;
    logic [7:0]        opcodeStage_q, opcodeStage_d;
    logic [ARGS_W-1:0] argStage_q, argStage_d;
    logic [7:0]        instr_q, instr_d;
    logic [ARGS_W-1:0] argOut_q, argOut_d;
    logic              start_q, start_d;
    logic              inFlight_q, inFlight_d;
    logic              overflow_q, overflow_d;
    logic              error_q, error_d;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) uCmdFifo (
        .clk_i      (phi2),
        .reset_n_i  (reset_n),
        .push_i     (fifoPush),
        .pushData_i (fifoPushData),
        .pop_i      (fifoPop),
        .popData_o  (fifoPopData),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    // Bus cycle decode; the trigger address follows the staged opcode
    always_comb begin
        sel        = ce0 && !ce1b;
        wrEn       = sel && !rw;
        rdEn       = sel && rw;
        execA      = ADDR_W'(exec_addr(opcodeStage_q, NUM_ARGS));
        statusRead = rdEn && (addr == STATUS_A);
        trigger    = wrEn && (addr == execA);
    end

    // Assemble the status byte the CPU sees
    always_comb begin
        statusByte                          = 8'h00;
        statusByte[ST_READY]                = !fifoFull;
        statusByte[ST_COUNT_HI:ST_COUNT_LO] = 3'(fifoCount);
        statusByte[ST_DONE]                 = doneBit;
        statusByte[ST_OVERFLOW]             = overflow_q;
        statusByte[ST_ERROR]                = error_q;
        statusByte[ST_BUSY]                 = inFlight_q || instruction_busy || !fifoEmpty;
    end

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        readData = 8'h00;
        if (addr == MODE_A)         readData = modeReg_q;
        else if (addr == OPCODE_A)  readData = opcodeStage_q;
        else if (addr == RESULT0_A) readData = result_0;
        else if (addr == RESULT1_A) readData = result_1;
        else if (addr == STATUS_A)  readData = statusByte;
        for (int k = 0; k < NUM_ARGS; k++) begin
            if (addr == ADDR_W'(ARG_BASE_ADDR + k)) readData = argStage_q[8*k +: 8];
        end
    end

    assign data_out = rdEn ? readData : 8'hZZ;

    // Register writes, command snapshot, executor issue and sticky flags
    always_comb begin
        modeReg_d     = modeReg_q;
        opcodeStage_d = opcodeStage_q;
        argStage_d    = argStage_q;
        if (wrEn) begin
            if (addr == MODE_A)   modeReg_d     = data_in;
            if (addr == OPCODE_A) opcodeStage_d = data_in;
            for (int k = 0; k < NUM_ARGS; k++) begin
                if (addr == ADDR_W'(ARG_BASE_ADDR + k)) argStage_d[8*k +: 8] = data_in;
            end
        end

        fifoPush     = trigger && !fifoFull;
        fifoPushData = {opcodeStage_d, argStage_d};

        completion = inFlight_q && (instruction_finished || instruction_error);
        issue      = !inFlight_q && !instruction_busy && !fifoEmpty;
        fifoPop    = issue;
        start_d    = issue;

        instr_d  = instr_q;
        argOut_d = argOut_q;
        if (issue) begin
            instr_d  = fifoPopData[CMD_W-1 -: 8];
            argOut_d = fifoPopData[ARGS_W-1:0];
        end

        inFlight_d = inFlight_q;
        if (issue) begin
            inFlight_d = 1'b1;
        end else if (completion) begin
            inFlight_d = 1'b0;
        end

        overflow_d = overflow_q && !statusRead;
        if (trigger && fifoFull) overflow_d = 1'b1;
        error_d = error_q && !statusRead;
        if ((trigger && fifoFull) || instruction_error) error_d = 1'b1;
    end

    // State registers for the register file and executor handshake
    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            modeReg_q     <= 8'h00;
            opcodeStage_q <= 8'h00;
            argStage_q    <= '0;
            instr_q       <= 8'h00;
            argOut_q      <= '0;
            start_q       <= 1'b0;
            inFlight_q    <= 1'b0;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            modeReg_q     <= modeReg_d;
            opcodeStage_q <= opcodeStage_d;
            argStage_q    <= argStage_d;
            instr_q       <= instr_d;
            argOut_q      <= argOut_d;
            start_q       <= start_d;
            inFlight_q    <= inFlight_d;
            overflow_q    <= overflow_d;
            error_q       <= error_d;
        end
    end

`ifdef CPU_CMDQ_IRQ_EN
    logic done_q, done_d;

    // Done flags the queue fully draining; a status read clears it unless set again
    always_comb begin
        done_d = done_q && !statusRead;
        if (completion && fifoEmpty && !fifoPush) done_d = 1'b1;
    end

    // Done flag register
    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign doneBit = done_q;
    assign irq_n   = !(modeReg_q[7] && (done_q || error_q));
`else
    assign doneBit = 1'b0;
`endif

    assign instruction       = instr_q;
    assign arg_data          = argOut_q;
    assign instruction_start = start_q;
    assign mode_control      = modeReg_q;

endmodule
